// File: rtl/imem_loader.sv
// Serial instruction-memory loader: parses a length/data/checksum byte frame and
// writes assembled 32-bit words to consecutive addresses, holding the core in reset.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | after reset, waiting for Start
// LEN0    | waiting for word count low byte
// LEN1    | waiting for word count high byte, range check
// DATA    | collecting byte lanes 0..3 of the current word
// WRITE   | one-cycle write strobe for the assembled word
// CHECK   | waiting for checksum byte
// DONE    | load good, core released
// ERROR   | bad checksum or oversize frame
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemData,
    output logic              MemWriteManual,
    output logic              CPUReset,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    // Capacity in words, saturated so it always fits the 17-bit compare.
    localparam logic [16:0] CAP = (ADDR_W - 2 >= 16) ? 17'h10000 : 17'(1 << (ADDR_W - 2));

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] len_q, len_d;
    logic [16:0] word_idx_q, word_idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  xor_q, xor_d;
    logic        accept;
    logic [16:0] n_new;

    assign ByteReady      = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                            (state_q == S_DATA) || (state_q == S_CHECK);
    assign Busy           = ByteReady || (state_q == S_WRITE);
    assign Done           = (state_q == S_DONE);
    assign Error          = (state_q == S_ERROR);
    assign CPUReset       = (state_q != S_DONE);
    assign MemWriteManual = (state_q == S_WRITE);
    assign MemData        = data_q;
    assign MemAddr        = ADDR_W'({word_idx_q, 2'b00});

    assign accept = ByteValid && ByteReady;
    assign n_new  = {1'b0, ByteIn, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        data_d     = data_q;
        xor_d      = xor_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Start) begin
                    state_d    = S_LEN0;
                    word_idx_d = '0;
                    xor_d      = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_lo_d = ByteIn;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d  = n_new[15:0];
                    lane_d = '0;
                    if (n_new > CAP)
                        state_d = S_ERROR;
                    else if (n_new == '0)
                        state_d = S_CHECK;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d  = xor_q ^ ByteIn;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: asm_d[7:0]   = ByteIn;
                        2'd1: asm_d[15:8]  = ByteIn;
                        2'd2: asm_d[23:16] = ByteIn;
                        default: begin
                            data_d  = {ByteIn, asm_q};
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 17'd1;
                state_d    = (word_idx_d == {1'b0, len_q}) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (accept)
                    state_d = (ByteIn == xor_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            lane_q     <= '0;
            asm_q      <= '0;
            data_q     <= '0;
            xor_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
            xor_q      <= xor_d;
        end
    end

endmodule
